// File: rtl/mpu_write_queue.sv
// MPU register interface and pending-write queue feeding the memory manager.
// Register writes are decoded into address, data, stride and fill count.
// {address, data} words go into a show-ahead FIFO. A hardware fill engine
// can push N copies of the latched data.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | MPU register writes honoured; data writes push one entry
// ST_FILL | one push per cycle while FIFO not full; regs 0-6 ignored
module mpu_write_queue #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clock,
    input  logic                             resetN,
    input  logic                             chipSelect,
    input  logic                             writeEnable,
    input  logic [2:0]                       registerSelect,
    input  logic [7:0]                       registerData,
    input  logic                             queueReadRequest,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] queueReadBus,
    output logic                             queueReadEmpty,
    output logic [$clog2(FIFO_DEPTH):0]      queueLevel,
    output logic                             busy,
    output logic                             overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    state_t                  state_q, state_d;
    logic                    strobe_q, strobe_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]              stride_q, stride_d;
    logic [15:0]             fill_count_q, fill_count_d;
    logic                    overflow_q, overflow_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           count_q, count_d;
    logic [EW-1:0]           mem_q [FIFO_DEPTH];

    logic                    strobe;
    logic                    wr_event;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    ctl_start;
    logic                    ctl_abort;
    logic                    ctl_clear;
    logic                    reg_write;
    logic                    push_en;
    logic                    pop_en;
    logic                    drop;
    logic [EW-1:0]           push_entry;

    // Edge detect on the MPU strobe plus FIFO status decode.
    always_comb begin
        strobe     = chipSelect & writeEnable;
        wr_event   = strobe & ~strobe_q;
        fifo_full  = (count_q == LW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        addr_next  = address_q + ADDR_WIDTH'(stride_q);
        ctl_start  = wr_event && (registerSelect == 3'd7) && registerData[0];
        ctl_abort  = wr_event && (registerSelect == 3'd7) && registerData[1];
        ctl_clear  = wr_event && (registerSelect == 3'd7) && registerData[2];
        reg_write  = wr_event && (registerSelect != 3'd7) && (state_q == ST_IDLE);
        pop_en     = queueReadRequest & ~fifo_empty;
    end

    // Fill FSM next state, register decode and push/drop decisions.
    always_comb begin
        state_d      = state_q;
        strobe_d     = strobe;
        address_d    = address_q;
        data_d       = data_q;
        stride_d     = stride_q;
        fill_count_d = fill_count_q;
        overflow_d   = overflow_q;
        push_en      = 1'b0;
        drop         = 1'b0;
        push_entry   = {address_q, data_q};

        case (state_q)
            ST_IDLE: begin
                // Abort wins when written together with start.
                if (ctl_start && !ctl_abort && (fill_count_q != 16'd0)) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (ctl_abort) begin
                    state_d = ST_IDLE;
                end else if (!fifo_full) begin
                    push_en      = 1'b1;
                    address_d    = addr_next;
                    fill_count_d = fill_count_q - 16'd1;
                    if (fill_count_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (reg_write) begin
            case (registerSelect)
                3'd0, 3'd1, 3'd2: begin
                    // Byte lane k of the address; bits beyond the width are discarded.
                    for (int i = 0; i < ADDR_WIDTH; i++) begin
                        if ((i / 8) == int'(registerSelect)) begin
                            address_d[i] = registerData[i % 8];
                        end
                    end
                end
                3'd3: begin
                    data_d     = registerData[DATA_WIDTH-1:0];
                    push_entry = {address_q, registerData[DATA_WIDTH-1:0]};
                    if (fifo_full) begin
                        drop = 1'b1;
                    end else begin
                        push_en   = 1'b1;
                        address_d = addr_next;
                    end
                end
                3'd4: stride_d = registerData;
                3'd5: fill_count_d[7:0] = registerData;
                3'd6: fill_count_d[15:8] = registerData;
                default: ;
            endcase
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (ctl_clear) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO pointer and occupancy bookkeeping; a same-cycle pop never frees room for a push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and FIFO state registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            strobe_q     <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
            stride_q     <= 8'd1;
            fill_count_q <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            strobe_q     <= strobe_d;
            address_q    <= address_d;
            data_q       <= data_d;
            stride_q     <= stride_d;
            fill_count_q <= fill_count_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Queue storage; contents are only visible through the head while non-empty.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign queueReadEmpty = fifo_empty;
    assign queueReadBus   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign queueLevel     = count_q;
    assign busy           = (state_q == ST_FILL);
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_mpu_write_queue.sv
// Bench for mpu_write_queue: directed scenarios plus a randomized run,
// all compared against a queue-based behavioural model.
module tb_mpu_write_queue;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int EW    = AW + DW;
    localparam int AMOD  = 1 << AW;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          chipSelect = 1'b0;
    logic          writeEnable = 1'b0;
    logic [2:0]    registerSelect = 3'd0;
    logic [7:0]    registerData = 8'd0;
    logic          queueReadRequest = 1'b0;
    logic [EW-1:0] queueReadBus;
    logic          queueReadEmpty;
    logic [4:0]    queueLevel;
    logic          busy;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    mpu_write_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .chipSelect(chipSelect),
        .writeEnable(writeEnable),
        .registerSelect(registerSelect),
        .registerData(registerData),
        .queueReadRequest(queueReadRequest),
        .queueReadBus(queueReadBus),
        .queueReadEmpty(queueReadEmpty),
        .queueLevel(queueLevel),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Behavioural model: registers as integers, the FIFO as a queue.
    int            m_addr, m_data, m_stride, m_fill;
    bit            m_busy, m_ovf, m_prev;
    logic [EW-1:0] m_q[$];

    always @(posedge clock or negedge resetN) begin : model
        bit            ev, st, ab, cl, push, pop, full, drp;
        logic [EW-1:0] ent;
        int            v;
        if (!resetN) begin
            m_addr = 0; m_data = 0; m_stride = 1; m_fill = 0;
            m_busy = 0; m_ovf = 0; m_prev = 0;
            m_q.delete();
        end else begin
            v    = int'(registerData);
            ev   = chipSelect && writeEnable && !m_prev;
            m_prev = chipSelect && writeEnable;
            full = (m_q.size() == DEPTH);
            pop  = queueReadRequest && (m_q.size() != 0);
            st   = ev && registerSelect == 3'd7 && registerData[0];
            ab   = ev && registerSelect == 3'd7 && registerData[1];
            cl   = ev && registerSelect == 3'd7 && registerData[2];
            push = 0; drp = 0; ent = '0;
            if (m_busy) begin
                if (ab) m_busy = 0;
                else if (!full) begin
                    ent = {AW'(m_addr), DW'(m_data)};
                    push = 1;
                    m_addr = (m_addr + m_stride) % AMOD;
                    m_fill = m_fill - 1;
                    if (m_fill == 0) m_busy = 0;
                end
            end else begin
                if (ev && registerSelect != 3'd7) begin
                    case (registerSelect)
                        3'd0: m_addr = (m_addr & ~32'hFF) | v;
                        3'd1: m_addr = (m_addr & ~32'hFF00) | (v << 8);
                        3'd2: m_addr = ((m_addr & 32'hFFFF) | (v << 16)) % AMOD;
                        3'd3: begin
                            m_data = v;
                            if (full) drp = 1;
                            else begin
                                ent = {AW'(m_addr), DW'(v)};
                                push = 1;
                                m_addr = (m_addr + m_stride) % AMOD;
                            end
                        end
                        3'd4: m_stride = v;
                        3'd5: m_fill = (m_fill & 32'hFF00) | v;
                        3'd6: m_fill = (m_fill & 32'hFF) | (v << 8);
                        default: ;
                    endcase
                end
                if (st && !ab && m_fill != 0) m_busy = 1;
            end
            if (cl) m_ovf = 0;
            if (drp) m_ovf = 1;
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(ent);
        end
    end

    function automatic logic [EW-1:0] m_head();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    // One register write event, called at a negedge; returns one idle cycle later.
    task automatic wr(input logic [2:0] sel, input logic [7:0] val);
        registerSelect = sel;
        registerData   = val;
        chipSelect     = 1'b1;
        writeEnable    = 1'b1;
        @(negedge clock);
        chipSelect  = 1'b0;
        writeEnable = 1'b0;
        @(negedge clock);
    endtask

    task automatic pop_one(output logic [EW-1:0] e);
        e = queueReadBus;
        queueReadRequest = 1'b1;
        @(negedge clock);
        queueReadRequest = 1'b0;
    endtask

    task automatic drain();
        logic [EW-1:0] e;
        for (int i = 0; i < 40 && !queueReadEmpty; i++) pop_one(e);
    endtask

    task automatic set_addr(input int a);
        wr(3'd0, 8'(a));
        wr(3'd1, 8'(a >> 8));
        wr(3'd2, 8'(a >> 16));
    endtask

    task automatic test_reset();
        checks++;
        if (queueReadEmpty !== 1'b1 || queueLevel !== 5'd0 || queueReadBus !== '0 ||
            busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got empty=%b level=%0d bus=%h busy=%b ovf=%b exp 1 0 0 0 0",
                     queueReadEmpty, queueLevel, queueReadBus, busy, overflow);
        end
    endtask

    task automatic test_basic();
        logic [EW-1:0] e;
        wr(3'd0, 8'h34); wr(3'd1, 8'h12); wr(3'd2, 8'h01); wr(3'd3, 8'hAA);
        checks++;
        if (queueReadBus !== 25'h11234AA || queueLevel !== 5'd1) begin
            errors++;
            $display("FAIL basic_first got bus=%h level=%0d exp 11234aa 1", queueReadBus, queueLevel);
        end
        wr(3'd3, 8'hBB);
        pop_one(e);
        checks++;
        if (queueReadBus !== 25'h11235BB || queueLevel !== 5'd1) begin
            errors++;
            $display("FAIL basic_second got bus=%h level=%0d exp 11235bb 1", queueReadBus, queueLevel);
        end
        drain();
    endtask

    task automatic test_wrap_and_hold();
        logic [EW-1:0] e;
        logic [7:0] v0, v1, v2;
        v0 = 8'($urandom); v1 = 8'($urandom); v2 = 8'($urandom);
        wr(3'd4, 8'd4);
        set_addr(32'h1FFFE);
        wr(3'd3, v0); wr(3'd3, v1);
        pop_one(e);
        checks++;
        if (e !== {17'h1FFFE, v0}) begin
            errors++; $display("FAIL wrap_first got %h exp %h", e, {17'h1FFFE, v0});
        end
        pop_one(e);
        checks++;
        if (e !== {17'h00002, v1}) begin
            errors++; $display("FAIL wrap_second got %h exp %h", e, {17'h00002, v1});
        end
        registerSelect = 3'd3; registerData = v2; chipSelect = 1'b1; writeEnable = 1'b1;
        repeat (10) @(negedge clock);
        chipSelect = 1'b0; writeEnable = 1'b0;
        @(negedge clock);
        checks++;
        if (queueLevel !== 5'd1 || queueReadBus !== {17'h00006, v2}) begin
            errors++;
            $display("FAIL held_strobe got level=%0d bus=%h exp 1 %h", queueLevel, queueReadBus, {17'h00006, v2});
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [EW-1:0] e;
        logic [7:0] vals[17];
        int b;
        b = int'($urandom_range(0, AMOD - 1));
        wr(3'd4, 8'd1);
        set_addr(b);
        for (int i = 0; i < 17; i++) begin
            vals[i] = 8'($urandom);
            wr(3'd3, vals[i]);
        end
        checks++;
        if (queueLevel !== 5'd16 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_full got level=%0d ovf=%b exp 16 1", queueLevel, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            pop_one(e);
            checks++;
            if (e !== {AW'((b + i) % AMOD), vals[i]}) begin
                errors++; $display("FAIL ovf_entry%0d got %h exp %h", i, e, {AW'((b + i) % AMOD), vals[i]});
            end
        end
        wr(3'd7, 8'h04);
        checks++;
        if (overflow !== 1'b0 || queueReadEmpty !== 1'b1) begin
            errors++; $display("FAIL ovf_clear got ovf=%b empty=%b exp 0 1", overflow, queueReadEmpty);
        end
        wr(3'd3, 8'hC3);
        checks++;
        if (queueReadBus !== {AW'((b + 16) % AMOD), 8'hC3}) begin
            errors++; $display("FAIL ovf_addr got %h exp %h", queueReadBus, {AW'((b + 16) % AMOD), 8'hC3});
        end
        drain();
    endtask

    task automatic test_fill();
        logic [EW-1:0] got[$];
        logic [EW-1:0] e;
        bit saw_full, saw_ovf;
        int cyc;
        wr(3'd4, 8'd1);
        set_addr(32'h000FF);
        wr(3'd3, 8'h5A);
        pop_one(e);
        wr(3'd5, 8'd40); wr(3'd6, 8'd0); wr(3'd7, 8'h01);
        saw_full = 0; saw_ovf = 0; cyc = 0;
        while (got.size() < 40 && cyc < 2000) begin
            checks++;
            if (busy !== m_busy) begin
                errors++; $display("FAIL fill_busy cycle %0d got %b exp %b", cyc, busy, m_busy);
            end
            if (queueLevel == 5'd16 && busy) saw_full = 1;
            if (overflow) saw_ovf = 1;
            if (cyc % 3 == 0 && !queueReadEmpty) begin
                got.push_back(queueReadBus);
                queueReadRequest = 1'b1;
            end else queueReadRequest = 1'b0;
            @(negedge clock);
            cyc++;
        end
        queueReadRequest = 1'b0;
        checks++;
        if (got.size() != 40 || !saw_full || saw_ovf || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_summary got n=%0d stalled=%b ovf=%b busy=%b exp 40 1 0 0",
                     got.size(), saw_full, saw_ovf, busy);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== {AW'(32'h100 + i), 8'h5A}) begin
                errors++; $display("FAIL fill_entry%0d got %h exp %h", i, got[i], {AW'(32'h100 + i), 8'h5A});
            end
        end
    endtask

    task automatic test_abort();
        logic [EW-1:0] e;
        logic [7:0] dv;
        int b, n;
        dv = 8'($urandom);
        b  = int'($urandom_range(0, AMOD - 1));
        wr(3'd4, 8'd1);
        wr(3'd3, dv);
        drain();
        set_addr(b);
        wr(3'd5, 8'hE8); wr(3'd6, 8'h03);
        wr(3'd7, 8'h01);
        wr(3'd0, 8'h55);
        n = 0;
        while (queueLevel != 5'd5 && n < 50) begin
            @(negedge clock);
            n++;
        end
        registerSelect = 3'd7; registerData = 8'h02; chipSelect = 1'b1; writeEnable = 1'b1;
        @(negedge clock);
        chipSelect = 1'b0; writeEnable = 1'b0;
        checks++;
        if (busy !== 1'b0 || queueLevel !== 5'd5) begin
            errors++; $display("FAIL abort_stop got busy=%b level=%0d exp 0 5", busy, queueLevel);
        end
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            pop_one(e);
            checks++;
            if (e !== {AW'((b + i) % AMOD), dv}) begin
                errors++; $display("FAIL abort_entry%0d got %h exp %h", i, e, {AW'((b + i) % AMOD), dv});
            end
        end
        wr(3'd3, 8'h77);
        checks++;
        if (queueReadBus !== {AW'((b + 5) % AMOD), 8'h77} || queueLevel !== 5'd1) begin
            errors++;
            $display("FAIL abort_addr got %h level=%0d exp %h 1", queueReadBus, queueLevel, {AW'((b + 5) % AMOD), 8'h77});
        end
        drain();
    endtask

    task automatic test_reset_mid_fill();
        logic [EW-1:0] e;
        wr(3'd4, 8'd1);
        for (int i = 0; i < 17; i++) wr(3'd3, 8'(i));
        for (int i = 0; i < 8; i++) pop_one(e);
        wr(3'd5, 8'd100); wr(3'd6, 8'd0); wr(3'd7, 8'h01);
        checks++;
        if (busy !== 1'b1 || overflow !== 1'b1 || queueReadEmpty !== 1'b0) begin
            errors++; $display("FAIL premid_state got busy=%b ovf=%b empty=%b exp 1 1 0", busy, overflow, queueReadEmpty);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (queueReadEmpty !== 1'b1 || queueLevel !== 5'd0 || queueReadBus !== '0 ||
            busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got empty=%b level=%0d bus=%h busy=%b ovf=%b exp 1 0 0 0 0",
                     queueReadEmpty, queueLevel, queueReadBus, busy, overflow);
        end
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        pop_one(e);
        checks++;
        if (queueReadEmpty !== 1'b1 || queueLevel !== 5'd0 || queueReadBus !== '0) begin
            errors++;
            $display("FAIL pop_empty got empty=%b level=%0d bus=%h exp 1 0 0", queueReadEmpty, queueLevel, queueReadBus);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] exp_bus;
        for (int c = 0; c < 600; c++) begin
            exp_bus = m_head();
            checks++;
            if (queueReadBus !== exp_bus || queueReadEmpty !== (m_q.size() == 0) ||
                queueLevel !== 5'(m_q.size()) || busy !== m_busy || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_c%0d got bus=%h lvl=%0d busy=%b ovf=%b exp bus=%h lvl=%0d busy=%b ovf=%b",
                         c, queueReadBus, queueLevel, busy, overflow, exp_bus, m_q.size(), m_busy, m_ovf);
            end
            if ($urandom_range(0, 9) < 4) begin
                chipSelect     = 1'b1;
                writeEnable    = ($urandom_range(0, 4) != 0);
                registerSelect = 3'($urandom_range(0, 7));
                registerData   = 8'($urandom);
                if (registerSelect == 3'd7) registerData = 8'($urandom_range(0, 7));
                if (registerSelect == 3'd6) registerData = 8'd0;
                if (registerSelect == 3'd5) registerData = 8'($urandom_range(0, 20));
            end else begin
                chipSelect  = 1'($urandom_range(0, 1));
                writeEnable = 1'b0;
            end
            queueReadRequest = ($urandom_range(0, 2) == 0);
            @(negedge clock);
        end
        chipSelect = 1'b0; writeEnable = 1'b0; queueReadRequest = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        test_reset();
        test_basic();
        test_wrap_and_hold();
        test_overflow();
        test_fill();
        test_abort();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
